vv_mac_seq_pe: RTL and testbench

Multi-lane, self-sequenced vector-dot-product MAC processing element for the dense-layer datapath. One activation stream (Q9.7) is broadcast to LANES parallel MACs, each with its own Q1.7 weight and Q1.14 bias. A transaction runs for a programmable vector length, then delivers one saturated Q3.14 result per lane through a valid/ready output. Activation flow control uses a valid/ready input handshake, and the block takes over the accumulate/clear/bias sequencing that the controller otherwise drives.

---
 rtl/vv_mac_seq_pe.sv | 170 +++++++++++++++++
 tb/tb_vv_mac_seq_pe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vv_mac_seq_pe.sv
`default_nettype none
// ============================================================================
// Module   : vv_mac_seq_pe
// Desc     : Multi-lane self-sequenced dot-product MAC PE; optional ReLU after
//            saturation enabled by defining MAC_PE_RELU_EN.
// Revision : 1.0  initial release
// ============================================================================
module vv_mac_seq_pe #(
   parameter int LANES    = 4,
   parameter int INPUT_W  = 16,
   parameter int WEIGHT_W = 8,
   parameter int BIAS_W   = 15,
   parameter int OUTPUT_W = 17,
   parameter int GUARD_W  = 10,
   parameter int LEN_W    = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         start,
   input  logic [LEN_W-1:0]             len,
   input  logic [LANES*BIAS_W-1:0]      bias,
   output logic                         busy,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [INPUT_W-1:0]           din,
   input  logic [LANES*WEIGHT_W-1:0]    weight,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LANES*OUTPUT_W-1:0]    dout,
   output logic [LANES-1:0]             sat_flag
);

   localparam int ACC_W  = INPUT_W + WEIGHT_W + GUARD_W;
   localparam int PROD_W = INPUT_W + WEIGHT_W;

   localparam logic [1:0]       c_st_idle = 2'd0;
   localparam logic [1:0]       c_st_acc  = 2'd1;
   localparam logic [1:0]       c_st_out  = 2'd2;
   localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_cnt;
   logic             w_start_go;
   logic             w_len_zero;
   logic             w_beat;
   logic             w_last;

   assign w_start_go = start && (r_state == c_st_idle);
   assign w_len_zero = (len == '0);
   assign w_beat     = in_valid && (r_state == c_st_acc);
   assign w_last     = w_beat && (r_cnt == (r_len - c_len_one));

   // Returns {clip_flag, value}; bits above the output sign must all match it.
   function automatic logic [OUTPUT_W:0] f_sat(input logic signed [ACC_W-1:0] x);
      logic [OUTPUT_W-1:0] v;
      logic                f;
      if ((&x[ACC_W-1:OUTPUT_W-1]) || !(|x[ACC_W-1:OUTPUT_W-1])) begin
         v = x[OUTPUT_W-1:0];
         f = 1'b0;
      end else if (x[ACC_W-1]) begin
         v = {1'b1, {(OUTPUT_W-1){1'b0}}};
         f = 1'b1;
      end else begin
         v = {1'b0, {(OUTPUT_W-1){1'b1}}};
         f = 1'b1;
      end
`ifdef MAC_PE_RELU_EN
      if (v[OUTPUT_W-1]) v = '0;
`else
`endif
      return {f, v};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_state <= c_st_idle;
      else if (clr)   r_state <= c_st_idle;
      else            r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle: if (start) w_next_state = w_len_zero ? c_st_out : c_st_acc;
         c_st_acc:  if (w_last) w_next_state = c_st_out;
         c_st_out:  if (out_ready) w_next_state = c_st_idle;
         default:   w_next_state = c_st_idle;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         c_st_acc: begin
            busy     = 1'b1;
            in_ready = 1'b1;
         end
         c_st_out: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_len <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (w_start_go) begin
         r_cnt <= '0;
         r_len <= len;
      end else if (w_beat) begin
         r_cnt <= r_cnt + c_len_one;
      end
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         logic signed [WEIGHT_W-1:0] w_w;
         logic signed [BIAS_W-1:0]   w_b;
         logic signed [PROD_W-1:0]   w_prod;
         logic signed [ACC_W-1:0]    w_bias_ext;
         logic signed [ACC_W-1:0]    w_sum;
         logic [OUTPUT_W:0]          w_sat_sum;
         logic [OUTPUT_W:0]          w_sat_bias;
         logic signed [ACC_W-1:0]    r_acc;
         logic [OUTPUT_W-1:0]        r_dout;
         logic                       r_sat;

         assign w_w        = weight[i*WEIGHT_W +: WEIGHT_W];
         assign w_b        = bias[i*BIAS_W +: BIAS_W];
         assign w_prod     = PROD_W'(w_w) * PROD_W'($signed(din));
         assign w_bias_ext = ACC_W'(w_b);
         assign w_sum      = r_acc + ACC_W'(w_prod);
         assign w_sat_sum  = f_sat(w_sum);
         assign w_sat_bias = f_sat(w_bias_ext);

         // Result is captured from the post-update sum on the final beat edge.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_acc  <= '0;
               r_dout <= '0;
               r_sat  <= 1'b0;
            end else if (clr) begin
               r_acc  <= '0;
               r_dout <= '0;
               r_sat  <= 1'b0;
            end else if (w_start_go) begin
               r_acc <= w_bias_ext;
               if (w_len_zero) {r_sat, r_dout} <= w_sat_bias;
            end else if (w_beat) begin
               r_acc <= w_sum;
               if (w_last) {r_sat, r_dout} <= w_sat_sum;
            end
         end

         assign dout[i*OUTPUT_W +: OUTPUT_W] = r_dout;
         assign sat_flag[i]                  = r_sat;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vv_mac_seq_pe.sv
`default_nettype none
// Testbench for vv_mac_seq_pe: randomized transactions against an integer
// dot-product reference, plus directed saturation/abort/reset scenarios.
module tb_vv_mac_seq_pe;

   localparam int LANES    = 4;
   localparam int INPUT_W  = 16;
   localparam int WEIGHT_W = 8;
   localparam int BIAS_W   = 15;
   localparam int OUTPUT_W = 17;
   localparam int GUARD_W  = 10;
   localparam int LEN_W    = 10;
   localparam int MAXB     = 8;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      clr;
   logic                      start;
   logic [LEN_W-1:0]          len;
   logic [LANES*BIAS_W-1:0]   bias;
   logic                      busy;
   logic                      in_valid;
   logic                      in_ready;
   logic [INPUT_W-1:0]        din;
   logic [LANES*WEIGHT_W-1:0] weight;
   logic                      out_valid;
   logic                      out_ready;
   logic [LANES*OUTPUT_W-1:0] dout;
   logic [LANES-1:0]          sat_flag;

   logic signed [WEIGHT_W-1:0] t_w    [MAXB][LANES];
   logic signed [INPUT_W-1:0]  t_d    [MAXB];
   logic signed [BIAS_W-1:0]   t_bias [LANES];
   int                         t_gap  [MAXB];

   int n_checks = 0;
   int n_pass   = 0;

   vv_mac_seq_pe #(
      .LANES(LANES), .INPUT_W(INPUT_W), .WEIGHT_W(WEIGHT_W), .BIAS_W(BIAS_W),
      .OUTPUT_W(OUTPUT_W), .GUARD_W(GUARD_W), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .len(len), .bias(bias),
      .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .din(din),
      .weight(weight), .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic fill_rand();
      int v;
      for (int b = 0; b < MAXB; b++) begin
         if ($urandom_range(0, 3) == 0) t_d[b] = INPUT_W'($urandom);
         else begin
            v = int'($urandom_range(0, 511)) - 256;
            t_d[b] = v[INPUT_W-1:0];
         end
         for (int l = 0; l < LANES; l++) t_w[b][l] = WEIGHT_W'($urandom);
         t_gap[b] = $urandom_range(0, 2);
      end
      for (int l = 0; l < LANES; l++) t_bias[l] = BIAS_W'($urandom);
   endtask

   // abort_at >= 0 asserts clr before that beat; rst_out pulses rst_n while results wait.
   task automatic do_txn(input int n, input int hold, input int abort_at, input bit rst_out);
      longint                    s;
      longint                    maxv;
      logic [OUTPUT_W-1:0]       e_d [LANES];
      logic                      e_f [LANES];
      logic [LANES*OUTPUT_W-1:0] snap;
      maxv = (longint'(1) << (OUTPUT_W - 1)) - 1;
      for (int l = 0; l < LANES; l++) begin
         s = longint'(t_bias[l]);
         for (int b = 0; b < n; b++) s += longint'(t_w[b][l]) * longint'(t_d[b]);
         e_f[l] = 1'b1;
         if (s > maxv)             e_d[l] = OUTPUT_W'(maxv);
         else if (s < -(maxv + 1)) e_d[l] = {1'b1, {(OUTPUT_W-1){1'b0}}};
         else begin
            e_d[l] = s[OUTPUT_W-1:0];
            e_f[l] = 1'b0;
         end
`ifdef MAC_PE_RELU_EN
         if (e_d[l][OUTPUT_W-1]) e_d[l] = '0;
`else
`endif
      end

      @(negedge clk);
      len = n[LEN_W-1:0];
      for (int l = 0; l < LANES; l++) bias[l*BIAS_W +: BIAS_W] = t_bias[l];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1'b1);
      check("in_ready_after_start", in_ready, n != 0);
      check("out_valid_after_start", out_valid, n == 0);

      for (int b = 0; b < n; b++) begin
         if (b == abort_at) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            check("abort_busy", busy, 1'b0);
            check("abort_in_ready", in_ready, 1'b0);
            check("abort_out_valid", out_valid, 1'b0);
            check("abort_dout", dout, '0);
            check("abort_sat", sat_flag, '0);
            in_valid = 1'b1;
            repeat (3) @(negedge clk);
            in_valid = 1'b0;
            check("abort_no_out_valid", out_valid, 1'b0);
            return;
         end
         in_valid = 1'b0;
         repeat (t_gap[b]) @(negedge clk);
         din = t_d[b];
         for (int l = 0; l < LANES; l++) weight[l*WEIGHT_W +: WEIGHT_W] = t_w[b][l];
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         din      = INPUT_W'($urandom);
      end

      check("out_valid_result", out_valid, 1'b1);
      check("in_ready_result", in_ready, 1'b0);
      for (int l = 0; l < LANES; l++) begin
         check($sformatf("dout_lane%0d", l), dout[l*OUTPUT_W +: OUTPUT_W], e_d[l]);
         check($sformatf("sat_lane%0d", l), sat_flag[l], e_f[l]);
      end

      snap = dout;
      for (int h = 0; h < hold; h++) begin
         start = (h == 0);
         len   = '0;
         @(negedge clk);
      end
      start = 1'b0;
      if (hold > 0) begin
         check("dout_stable", dout, snap);
         check("out_valid_held", out_valid, 1'b1);
         check("busy_held", busy, 1'b1);
      end

      if (rst_out) begin
         rst_n = 1'b0;
         #1;
         check("rst_out_valid", out_valid, 1'b0);
         check("rst_busy", busy, 1'b0);
         check("rst_dout", dout, '0);
         check("rst_sat", sat_flag, '0);
         @(negedge clk);
         rst_n = 1'b1;
         return;
      end

      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_after_hs", out_valid, 1'b0);
      check("busy_after_hs", busy, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; start = 1'b0; len = '0; bias = '0;
      in_valid = 1'b0; din = '0; weight = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_in_ready", in_ready, 1'b0);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_dout", dout, '0);
      check("reset_sat", sat_flag, '0);
      rst_n = 1'b1;

      // basic single beat
      fill_rand();
      for (int l = 0; l < LANES; l++) t_bias[l] = '0;
      t_w[0][0] = 8'h7F; t_d[0] = 16'h0080; t_gap[0] = 0;
      do_txn(1, 0, -1, 1'b0);
      check("basic_dout0_const", dout[OUTPUT_W-1:0], 17'h03F80);

      // positive saturation over 4 beats
      fill_rand();
      for (int l = 0; l < LANES; l++) t_bias[l] = '0;
      for (int b = 0; b < 4; b++) begin t_w[b][0] = 8'h7F; t_d[b] = 16'h7FFF; end
      do_txn(4, 1, -1, 1'b0);
      check("pos_sat_dout0_const", dout[OUTPUT_W-1:0], 17'h0FFFF);
      check("pos_sat_flag0_const", sat_flag[0], 1'b1);

      // negative saturation
      fill_rand();
      t_w[0][1] = 8'h80; t_d[0] = 16'h7FFF;
      do_txn(1, 0, -1, 1'b0);
`ifdef MAC_PE_RELU_EN
      check("neg_sat_dout1_const", dout[OUTPUT_W +: OUTPUT_W], 17'h00000);
`else
      check("neg_sat_dout1_const", dout[OUTPUT_W +: OUTPUT_W], 17'h10000);
`endif
      check("neg_sat_flag1_const", sat_flag[1], 1'b1);

      // bias only
      fill_rand();
      t_bias[0] = 15'h2000;
      do_txn(0, 0, -1, 1'b0);
      check("bias_only_dout0_const", dout[OUTPUT_W-1:0], 17'h02000);

      // backpressure with input gaps and held output
      fill_rand();
      t_gap[0] = 0; t_gap[1] = 2; t_gap[2] = 1;
      do_txn(3, 5, -1, 1'b0);

      // abort after 2 of 5 beats, then a fresh single-beat transaction
      fill_rand();
      do_txn(5, 0, 2, 1'b0);
      fill_rand();
      do_txn(1, 0, -1, 1'b0);

      // async reset while results are waiting
      fill_rand();
      do_txn(2, 2, -1, 1'b1);

      for (int k = 0; k < 25; k++) begin
         fill_rand();
         do_txn($urandom_range(0, MAXB), $urandom_range(0, 3), -1, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
